// File: rtl/sprite_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_regs_pkg
//  Purpose  : Shared constants and types for the sprite register master:
//             register count, coordinate width, register index names,
//             display reset defaults and FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package sprite_regs_pkg;

  localparam int NREGS   = 10;
  localparam int COORD_W = 8;
  localparam int IDX_W   = 4;

  typedef logic [COORD_W-1:0] coord_t;

  // Display-side register map, in address order
  typedef enum logic [IDX_W-1:0] {
    DINO_X     = 4'd0,
    DINO_Y     = 4'd1,
    JUMP_X     = 4'd2,
    JUMP_Y     = 4'd3,
    DUCK_X     = 4'd4,
    DUCK_Y     = 4'd5,
    SCAC_X     = 4'd6,
    SCAC_Y     = 4'd7,
    GODZILLA_X = 4'd8,
    GODZILLA_Y = 4'd9
  } reg_idx_e;

  // Mirrors the display block's 8-bit reset values so that nothing needs to
  // be pushed after reset until game logic actually moves a sprite
  localparam coord_t c_shadow_reset [NREGS] = '{
    8'd100, 8'd100, 8'd200, 8'd150, 8'd44,
    8'd200, 8'd244, 8'd100, 8'd100, 8'd4
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sprite_reg_master.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_reg_master
//  Purpose  : Avalon-MM write initiator. Game logic loads coordinates into a
//             shadow file at any time; on each frame-start pulse the changed
//             entries are snapshotted and written to the sprite display block
//             in ascending address order, one transfer at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_reg_master
  import sprite_regs_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic [COORD_W-1:0] load_data,
  input  logic               frame_start,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [DATA_W-1:0]  avm_writedata,
  output logic               avm_write,
  output logic               avm_chipselect,
  input  logic               avm_waitrequest,
  output logic               busy,
  output logic               done,
  output logic [7:0]         overrun_count
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NREGS - 1);
  localparam logic [IDX_W-1:0] c_nregs    = IDX_W'(NREGS);

  state_e             r_state;
  state_e             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [NREGS-1:0]   r_dirty;
  logic [NREGS-1:0]   r_pending;
  coord_t             r_shadow [NREGS];
  coord_t             r_snap   [NREGS];

  logic               w_snapshot;
  logic               w_advance;
  logic               w_accept;
  logic               w_load_ok;

  assign w_load_ok = load && (load_idx < c_nregs);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, bus outputs and datapath strobes. The last index jumps
  // straight to DONE so a pass costs exactly one cycle per clean entry and
  // two per dirty entry, with no trailing end-of-table cycle.
  always_comb begin
    w_state_next   = r_state;
    w_snapshot     = 1'b0;
    w_advance      = 1'b0;
    w_accept       = 1'b0;
    avm_write      = 1'b0;
    avm_chipselect = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    busy           = (r_state != IDLE);
    done           = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_snapshot   = 1'b1;
          w_state_next = SCAN;
        end
      end
      SCAN: begin
        if (r_pending[r_idx]) begin
          w_state_next = WRITE;
        end else begin
          w_advance = 1'b1;
          if (r_idx >= c_last_idx) begin
            w_state_next = DONE;
          end
        end
      end
      WRITE: begin
        avm_write      = 1'b1;
        avm_chipselect = 1'b1;
        avm_address    = ADDR_W'(r_idx);
        avm_writedata  = DATA_W'(r_snap[r_idx]);
        if (!avm_waitrequest) begin
          w_accept     = 1'b1;
          w_advance    = 1'b1;
          w_state_next = (r_idx >= c_last_idx) ? DONE : SCAN;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Snapshot and scan pointer: frozen copy of the shadow file plus the
  // per-entry "still to send" flags for the current pass
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap    <= c_shadow_reset;
      r_pending <= '0;
      r_idx     <= '0;
    end else if (w_snapshot) begin
      r_snap    <= r_shadow;
      r_pending <= r_dirty;
      r_idx     <= '0;
    end else begin
      if (w_accept) begin
        r_pending[r_idx] <= 1'b0;
      end
      if (w_advance) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  // Shadow file and dirty flags; a load in the snapshot cycle re-marks its
  // entry dirty after the clear so the new value goes out next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= c_shadow_reset;
      r_dirty  <= '0;
    end else begin
      if (w_snapshot) begin
        r_dirty <= '0;
      end
      if (w_load_ok) begin
        r_shadow[load_idx] <= load_data;
        r_dirty[load_idx]  <= 1'b1;
      end
    end
  end

  // Saturating count of frame pulses that arrived while a pass was running
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_count <= '0;
    end else if (frame_start && (r_state != IDLE) && (overrun_count != 8'hFF)) begin
      overrun_count <= overrun_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_reg_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_reg_master
//  Purpose  : Self-checking bench for sprite_reg_master. A transaction-level
//             model turns each frame into a list of time slots (one per
//             index, plus one per dirty index carrying the expected write)
//             and every cycle's outputs are compared against the slot at the
//             head of that list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_reg_master;
  import sprite_regs_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  localparam logic [7:0] DEF [10] = '{
    8'd100, 8'd100, 8'd200, 8'd150, 8'd44, 8'd200, 8'd244, 8'd100, 8'd100, 8'd4
  };

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               load = 1'b0;
  logic [3:0]         load_idx = '0;
  logic [7:0]         load_data = '0;
  logic               frame_start = 1'b0;
  logic               avm_waitrequest = 1'b0;
  logic [ADDR_W-1:0]  avm_address;
  logic [DATA_W-1:0]  avm_writedata;
  logic               avm_write;
  logic               avm_chipselect;
  logic               busy;
  logic               done;
  logic [7:0]         overrun_count;

  sprite_reg_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .load            (load),
    .load_idx        (load_idx),
    .load_data       (load_data),
    .frame_start     (frame_start),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_write       (avm_write),
    .avm_chipselect  (avm_chipselect),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .overrun_count   (overrun_count)
  );

  always #5 clk = ~clk;

  // One slot of a frame pass: w=1 slots carry the write expected on the bus
  typedef struct {
    bit          w;
    int unsigned addr;
    logic [7:0]  data;
  } tok_t;

  logic [7:0] m_shadow [10];
  bit         m_dirty  [10];
  tok_t       m_q [$];
  int         m_phase = P_IDLE;
  int         m_overrun = 0;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int fs_edge = 0;
  int done_at = -1;
  int accepted = 0;
  int write_hi = 0;
  bit obs_write = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model update for one clock edge, given the inputs present at that edge
  task automatic model_edge(input bit rst, input bit ld, input int li, input int lv,
                            input bit fs, input bit wr);
    int old_phase;
    if (rst) begin
      m_shadow  = DEF;
      foreach (m_dirty[i]) m_dirty[i] = 1'b0;
      m_q.delete();
      m_phase   = P_IDLE;
      m_overrun = 0;
      return;
    end
    old_phase = m_phase;
    case (m_phase)
      P_RUN: begin
        if (!(m_q[0].w && wr)) void'(m_q.pop_front());
        if (m_q.size() == 0) m_phase = P_DONE;
      end
      P_DONE: m_phase = P_IDLE;
      default: begin
        if (fs) begin
          for (int i = 0; i < 10; i++) begin
            m_q.push_back('{w: 1'b0, addr: i, data: 8'h00});
            if (m_dirty[i]) m_q.push_back('{w: 1'b1, addr: i, data: m_shadow[i]});
            m_dirty[i] = 1'b0;
          end
          m_phase = P_RUN;
        end
      end
    endcase
    if (fs && old_phase != P_IDLE && m_overrun < 255) m_overrun++;
    if (ld && li < 10) begin
      m_shadow[li] = 8'(lv);
      m_dirty[li]  = 1'b1;
    end
  endtask

  task automatic check_all();
    bit ew;
    ew = (m_phase == P_RUN) && m_q[0].w;
    chk("busy",           32'(busy),           32'(m_phase != P_IDLE));
    chk("done",           32'(done),           32'(m_phase == P_DONE));
    chk("avm_write",      32'(avm_write),      32'(ew));
    chk("avm_chipselect", 32'(avm_chipselect), 32'(ew));
    chk("avm_address",    32'(avm_address),    ew ? 32'(m_q[0].addr) : 32'd0);
    chk("avm_writedata",  avm_writedata,       ew ? 32'(m_q[0].data) : 32'd0);
    chk("overrun_count",  32'(overrun_count),  32'(m_overrun));
    obs_write = avm_write;
    if (avm_write) write_hi++;
    if (done) done_at = edge_no;
  endtask

  task automatic tick(input bit rst, input bit ld, input int li, input int lv,
                      input bit fs, input bit wr);
    reset = rst; load = ld; load_idx = 4'(li); load_data = 8'(lv);
    frame_start = fs; avm_waitrequest = wr;
    @(posedge clk);
    edge_no++;
    if (!rst && obs_write && !wr) accepted++;
    model_edge(rst, ld, li, lv, fs, wr);
    #1;
    check_all();
  endtask

  task automatic start_frame();
    accepted = 0; write_hi = 0; done_at = -1;
    tick(0, 0, 0, 0, 1, 0);
    fs_edge = edge_no;
  endtask

  // Run until the model says the pass is over, stalling the first 'stalls'
  // write cycles with waitrequest
  task automatic run_pass(input int stalls);
    int guard = 0;
    bit wr;
    while (m_phase != P_IDLE && guard < 200) begin
      wr = (m_phase == P_RUN) && m_q[0].w && (stalls > 0);
      if (wr) stalls--;
      tick(0, 0, 0, 0, 0, wr);
      guard++;
    end
    chk("pass_bound", 32'(guard < 200), 32'd1);
  endtask

  task automatic chk_shadow_defaults();
    for (int i = 0; i < 10; i++) chk("shadow_default", 32'(dut.r_shadow[i]), 32'(DEF[i]));
  endtask

  initial begin
    // Reset state
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk_shadow_defaults();

    // No loads: no writes, done on cycle 11
    start_frame();
    run_pass(0);
    chk("p1_done_cycle", 32'(done_at - fs_edge + 1), 32'd11);
    chk("p1_accepted", 32'(accepted), 32'd0);

    // Two dirty entries, no stall
    tick(0, 1, 0, 42, 0, 0);
    tick(0, 1, 6, 17, 0, 0);
    start_frame();
    run_pass(0);
    chk("p2_done_cycle", 32'(done_at - fs_edge + 1), 32'd13);
    chk("p2_accepted", 32'(accepted), 32'd2);
    chk("p2_write_hi", 32'(write_hi), 32'd2);

    // Same loads, first write stalled 3 cycles
    tick(0, 1, 0, 42, 0, 0);
    tick(0, 1, 6, 17, 0, 0);
    start_frame();
    run_pass(3);
    chk("p3_done_cycle", 32'(done_at - fs_edge + 1), 32'd16);
    chk("p3_accepted", 32'(accepted), 32'd2);
    chk("p3_write_hi", 32'(write_hi), 32'd5);

    // Overrun while busy; load during busy goes out next frame
    tick(0, 1, 3, 55, 0, 0);
    start_frame();
    tick(0, 1, 5, 99, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    run_pass(0);
    chk("p4_overrun", 32'(overrun_count), 32'd1);
    chk("p4_accepted", 32'(accepted), 32'd1);
    start_frame();
    run_pass(0);
    chk("p5_accepted", 32'(accepted), 32'd1);

    // Load in the same cycle as frame_start
    accepted = 0; write_hi = 0; done_at = -1;
    tick(0, 1, 2, 77, 1, 0);
    fs_edge = edge_no;
    run_pass(0);
    chk("p6_accepted", 32'(accepted), 32'd0);
    start_frame();
    run_pass(0);
    chk("p7_accepted", 32'(accepted), 32'd1);

    // Out-of-range index ignored
    tick(0, 1, 12, 33, 0, 0);
    start_frame();
    run_pass(0);
    chk("p8_accepted", 32'(accepted), 32'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      tick(0, ($urandom % 4) == 0, int'($urandom % 16), int'($urandom % 256),
           ($urandom % 25) == 0, ($urandom % 3) == 0);
    end
    run_pass(0);

    // Reset in the middle of a stalled write
    tick(0, 1, 4, 1, 0, 0);
    start_frame();
    for (int g = 0; g < 40 && !((m_phase == P_RUN) && m_q[0].w); g++) tick(0, 0, 0, 0, 0, 1);
    chk("mid_write_reached", 32'(avm_write), 32'd1);
    tick(1, 0, 0, 0, 0, 1);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_shadow_defaults();
    tick(0, 0, 0, 0, 0, 0);
    start_frame();
    run_pass(0);
    chk("post_rst_accepted", 32'(accepted), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
